// File: rtl/mgmt_wb_pkg.sv
// Shared types and default constants for the management Wishbone arbiter.
package mgmt_wb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
    typedef enum logic [1:0] {TGT_NONE, TGT_HK, TGT_MPRJ} tgt_t;

    localparam logic [7:0]  HK_BASE_DEF   = 8'h26;
    localparam logic [7:0]  MPRJ_BASE_DEF = 8'h30;
    localparam logic [31:0] ERR_DATA_DEF  = 32'hDEAD_BEEF;

    function automatic tgt_t decode_tgt(input logic [7:0] page,
                                        input logic [7:0] hk_base,
                                        input logic [7:0] mprj_base);
        if (page == hk_base)
            return TGT_HK;
        else if (page == mprj_base)
            return TGT_MPRJ;
        else
            return TGT_NONE;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter2.sv
// Two-way round-robin grant with a last-owner register updated on completion.
module wb_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic [1:0] upd_owner,
    output logic [1:0] gnt
);

    logic [1:0] last_grant;

    // Reset to m1 so that m0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 2'b10;
        else if (upd)
            last_grant <= upd_owner;
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant[0] ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mgmt_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the housekeeping and user-project ports.
// Optional slave-ack watchdog enabled by defining MGMT_WB_ARB_TIMEOUT_EN.
module mgmt_wb_arbiter
    import mgmt_wb_pkg::*;
#(
    parameter int unsigned  TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]   HK_BASE        = HK_BASE_DEF,
    parameter logic [7:0]   MPRJ_BASE      = MPRJ_BASE_DEF,
    parameter logic [31:0]  ERR_DATA       = ERR_DATA_DEF
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        mprj_cyc_o,
    output logic        mprj_stb_o,
    output logic        mprj_wb_iena,
    input  logic        mprj_ack_i,
    input  logic [31:0] mprj_dat_i,
    output logic        hk_cyc_o,
    output logic        hk_stb_o,
    input  logic        hk_ack_i,
    input  logic [31:0] hk_dat_i,
    output logic [1:0]  grant_o,
    output logic        err_o
);

    state_t      state, state_d;
    tgt_t        tgt, tgt_d;
    logic [1:0]  grant_d, gnt, arb_req;
    logic        we_d, hk_cyc_d, mprj_cyc_d, iena_d;
    logic        m0_ack_d, m1_ack_d, err_d, upd;
    logic [3:0]  sel_d;
    logic [31:0] adr_d, dat_d, m0_dat_d, m1_dat_d, done_dat;
    logic        done, abort, owner_cyc, tgt_ack;
    logic [31:0] tgt_dat;

`ifdef MGMT_WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt, cnt_d;
`endif

    // No new arbitration while the previous ack is still on the bus.
    assign arb_req = (state == ST_IDLE && !(m0_ack_o || m1_ack_o))
                   ? {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i} : 2'b00;

    assign owner_cyc = (grant_o[0] & m0_cyc_i) | (grant_o[1] & m1_cyc_i);
    assign tgt_ack   = (tgt == TGT_HK   && hk_cyc_o   && hk_ack_i)
                     | (tgt == TGT_MPRJ && mprj_cyc_o && mprj_ack_i);
    assign tgt_dat   = (tgt == TGT_HK) ? hk_dat_i : mprj_dat_i;

    wb_rr_arbiter2 u_rr (
        .clk       (core_clk),
        .rst       (core_rst),
        .req       (arb_req),
        .upd       (upd),
        .upd_owner (grant_o),
        .gnt       (gnt)
    );

    always_comb begin
        state_d    = state;
        tgt_d      = tgt;
        grant_d    = grant_o;
        we_d       = s_we_o;
        sel_d      = s_sel_o;
        adr_d      = s_adr_o;
        dat_d      = s_dat_o;
        hk_cyc_d   = hk_cyc_o;
        mprj_cyc_d = mprj_cyc_o;
        iena_d     = mprj_wb_iena;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_dat_d   = m0_dat_o;
        m1_dat_d   = m1_dat_o;
        err_d      = 1'b0;
        upd        = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        done_dat   = ERR_DATA;
`ifdef MGMT_WB_ARB_TIMEOUT_EN
        cnt_d      = cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (|gnt) begin
                    grant_d = gnt;
                    if (gnt[1]) begin
                        we_d  = m1_we_i;
                        sel_d = m1_sel_i;
                        adr_d = m1_adr_i;
                        dat_d = m1_dat_i;
                    end else begin
                        we_d  = m0_we_i;
                        sel_d = m0_sel_i;
                        adr_d = m0_adr_i;
                        dat_d = m0_dat_i;
                    end
                    tgt_d   = decode_tgt(adr_d[31:24], HK_BASE, MPRJ_BASE);
                    iena_d  = (tgt_d == TGT_MPRJ);
                    state_d = (tgt_d == TGT_NONE) ? ST_RESP : ST_BUSY;
`ifdef MGMT_WB_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (!owner_cyc) begin
                    abort = 1'b1;
                end else if (tgt_ack) begin
                    done     = 1'b1;
                    done_dat = tgt_dat;
`ifdef MGMT_WB_ARB_TIMEOUT_EN
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    done  = 1'b1;
                    err_d = 1'b1;
`endif
                end else begin
                    hk_cyc_d   = (tgt == TGT_HK);
                    mprj_cyc_d = (tgt == TGT_MPRJ);
`ifdef MGMT_WB_ARB_TIMEOUT_EN
                    cnt_d      = cnt + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                if (!owner_cyc) begin
                    abort = 1'b1;
                end else begin
                    done  = 1'b1;
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done || abort) begin
            state_d    = ST_IDLE;
            tgt_d      = TGT_NONE;
            grant_d    = 2'b00;
            hk_cyc_d   = 1'b0;
            mprj_cyc_d = 1'b0;
            iena_d     = 1'b0;
        end
        if (done) begin
            upd      = 1'b1;
            m0_ack_d = grant_o[0];
            m1_ack_d = grant_o[1];
            if (grant_o[0]) m0_dat_d = done_dat;
            if (grant_o[1]) m1_dat_d = done_dat;
        end
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state        <= ST_IDLE;
            tgt          <= TGT_NONE;
            grant_o      <= 2'b00;
            s_we_o       <= 1'b0;
            s_sel_o      <= 4'h0;
            s_adr_o      <= 32'h0;
            s_dat_o      <= 32'h0;
            hk_cyc_o     <= 1'b0;
            hk_stb_o     <= 1'b0;
            mprj_cyc_o   <= 1'b0;
            mprj_stb_o   <= 1'b0;
            mprj_wb_iena <= 1'b0;
            m0_ack_o     <= 1'b0;
            m1_ack_o     <= 1'b0;
            m0_dat_o     <= 32'h0;
            m1_dat_o     <= 32'h0;
            err_o        <= 1'b0;
        end else begin
            state        <= state_d;
            tgt          <= tgt_d;
            grant_o      <= grant_d;
            s_we_o       <= we_d;
            s_sel_o      <= sel_d;
            s_adr_o      <= adr_d;
            s_dat_o      <= dat_d;
            hk_cyc_o     <= hk_cyc_d;
            hk_stb_o     <= hk_cyc_d;
            mprj_cyc_o   <= mprj_cyc_d;
            mprj_stb_o   <= mprj_cyc_d;
            mprj_wb_iena <= iena_d;
            m0_ack_o     <= m0_ack_d;
            m1_ack_o     <= m1_ack_d;
            m0_dat_o     <= m0_dat_d;
            m1_dat_o     <= m1_dat_d;
            err_o        <= err_d;
        end
    end

`ifdef MGMT_WB_ARB_TIMEOUT_EN
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst)
            cnt <= '0;
        else
            cnt <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_mgmt_wb_arbiter.sv
// Directed bench for mgmt_wb_arbiter; timeout expectations follow MGMT_WB_ARB_TIMEOUT_EN.
module tb_mgmt_wb_arbiter;

    logic        core_clk = 1'b0;
    logic        core_rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m0_ack_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_ack_o;
    logic [31:0] m1_dat_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        mprj_cyc_o, mprj_stb_o, mprj_wb_iena, mprj_ack_i;
    logic [31:0] mprj_dat_i;
    logic        hk_cyc_o, hk_stb_o, hk_ack_i;
    logic [31:0] hk_dat_i;
    logic [1:0]  grant_o;
    logic        err_o;

    int n_vec = 0;
    int n_mis = 0;

    // Slave responder: ack when the strobe has been seen lat times (-1: never).
    logic slv_en = 1'b1;
    int   hk_lat = 1, mprj_lat = 1, hk_n = 0, mprj_n = 0;

    always #5 core_clk = ~core_clk;

    mgmt_wb_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
        .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .mprj_cyc_o(mprj_cyc_o), .mprj_stb_o(mprj_stb_o), .mprj_wb_iena(mprj_wb_iena),
        .mprj_ack_i(mprj_ack_i), .mprj_dat_i(mprj_dat_i),
        .hk_cyc_o(hk_cyc_o), .hk_stb_o(hk_stb_o), .hk_ack_i(hk_ack_i), .hk_dat_i(hk_dat_i),
        .grant_o(grant_o), .err_o(err_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge core_clk);
        #1;
    endtask

    task automatic m0_set(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = we;
        m0_sel_i = 4'hF; m0_adr_i = adr; m0_dat_i = dat;
    endtask

    task automatic m1_set(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = we;
        m1_sel_i = 4'h3; m1_adr_i = adr; m1_dat_i = dat;
    endtask

    initial begin
        forever begin
            @(negedge core_clk);
            if (slv_en) begin
                hk_n       = hk_stb_o ? hk_n + 1 : 0;
                mprj_n     = mprj_stb_o ? mprj_n + 1 : 0;
                hk_ack_i   = hk_stb_o && (hk_n == hk_lat);
                mprj_ack_i = mprj_stb_o && (mprj_n == mprj_lat);
            end
        end
    end

    // Tie between both masters on the user project; m0 first, then m1.
    task automatic run_pair(input string p, input logic [31:0] d0, input logic [31:0] d1);
        int a0, a1, n0, n1;
        a0 = 0; a1 = 0; n0 = 0; n1 = 0;
        mprj_lat = 1;
        m0_set(1'b1, 32'h3000_0000, d0);
        m1_set(1'b1, 32'h3000_0000, d1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) begin
                check_val({p, "_grant_first"}, 32'(grant_o), 32'h1);
                check_val({p, "_sdat_m0"}, s_dat_o, d0);
            end
            if (i == 2) check_val({p, "_iena"}, 32'(mprj_wb_iena), 32'h1);
            if (i == 5) begin
                check_val({p, "_grant_second"}, 32'(grant_o), 32'h2);
                check_val({p, "_sdat_m1"}, s_dat_o, d1);
                check_val({p, "_ssel_m1"}, 32'(s_sel_o), 32'h3);
            end
            if (m0_ack_o) begin n0++; if (a0 == 0) a0 = i; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
            if (m1_ack_o) begin n1++; if (a1 == 0) a1 = i; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
        end
        check_val({p, "_m0_ack_cycle"}, 32'(a0), 32'd3);
        check_val({p, "_m1_ack_cycle"}, 32'(a1), 32'd7);
        check_val({p, "_m0_ack_count"}, 32'(n0), 32'd1);
        check_val({p, "_m1_ack_count"}, 32'(n1), 32'd1);
    endtask

    initial begin
        int stb_n, mp_n, ack_n, ack_at, err_n, oth_n, err_w_ack;
        logic [31:0] got_dat;

        core_rst = 1'b1;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
        hk_ack_i = 0; mprj_ack_i = 0; hk_dat_i = 0; mprj_dat_i = 32'h5555_AAAA;
        tick(); tick();
        check_val("rst_grant", 32'(grant_o), 32'h0);
        check_val("rst_acks", {30'h0, m1_ack_o, m0_ack_o}, 32'h0);
        check_val("rst_strobes", {28'h0, hk_cyc_o, hk_stb_o, mprj_cyc_o, mprj_stb_o}, 32'h0);
        check_val("rst_err", 32'(err_o), 32'h0);
        core_rst = 1'b0;
        tick();

        run_pair("pair1", 32'hA0A0_0001, 32'hB1B1_0001);
        tick();
        run_pair("pair2", 32'hA0A0_0002, 32'hB1B1_0002);
        tick();

        // m0 housekeeping read, ack on the third strobe cycle.
        hk_lat = 3; hk_dat_i = 32'h1234_5678;
        m0_set(1'b0, 32'h2600_0004, 32'h0);
        stb_n = 0; mp_n = 0; ack_n = 0; ack_at = 0; err_n = 0; oth_n = 0; got_dat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) begin
                check_val("hk_grant", 32'(grant_o), 32'h1);
                check_val("hk_sadr", s_adr_o, 32'h2600_0004);
                check_val("hk_cyc_not_yet", 32'(hk_cyc_o), 32'h0);
            end
            if (hk_stb_o) stb_n++;
            if (mprj_cyc_o) mp_n++;
            if (err_o) err_n++;
            if (m1_ack_o) oth_n++;
            if (m0_ack_o) begin
                ack_n++; ack_at = i; got_dat = m0_dat_o;
                m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
            end
        end
        check_val("hk_stb_cycles", 32'(stb_n), 32'd3);
        check_val("hk_mprj_idle", 32'(mp_n), 32'd0);
        check_val("hk_ack_count", 32'(ack_n), 32'd1);
        check_val("hk_ack_cycle", 32'(ack_at), 32'd5);
        check_val("hk_rdata", got_dat, 32'h1234_5678);
        check_val("hk_no_err", 32'(err_n), 32'd0);
        check_val("hk_no_m1_ack", 32'(oth_n), 32'd0);

        // m1 unmapped read.
        m1_set(1'b0, 32'h1000_0000, 32'h0);
        stb_n = 0; ack_n = 0; ack_at = 0; err_n = 0; oth_n = 0; err_w_ack = 0; got_dat = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) check_val("unm_grant", 32'(grant_o), 32'h2);
            if (hk_cyc_o || mprj_cyc_o) stb_n++;
            if (err_o) err_n++;
            if (m0_ack_o) oth_n++;
            if (m1_ack_o) begin
                ack_n++; ack_at = i; got_dat = m1_dat_o; err_w_ack = 32'(err_o);
                m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
            end
        end
        check_val("unm_no_strobe", 32'(stb_n), 32'd0);
        check_val("unm_ack_cycle", 32'(ack_at), 32'd2);
        check_val("unm_ack_count", 32'(ack_n), 32'd1);
        check_val("unm_rdata", got_dat, 32'hDEAD_BEEF);
        check_val("unm_err_count", 32'(err_n), 32'd1);
        check_val("unm_err_with_ack", 32'(err_w_ack), 32'd1);
        check_val("unm_no_m0_ack", 32'(oth_n), 32'd0);

        // m0 abandons a user-project cycle; a late ack must be ignored.
        slv_en = 1'b0; mprj_ack_i = 1'b0;
        m0_set(1'b1, 32'h3000_0010, 32'h0BAD_0BAD);
        tick();
        check_val("abt_grant", 32'(grant_o), 32'h1);
        tick();
        check_val("abt_cyc_up", 32'(mprj_cyc_o), 32'h1);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        check_val("abt_cyc_down", 32'(mprj_cyc_o), 32'h0);
        check_val("abt_no_ack", 32'(m0_ack_o), 32'h0);
        mprj_ack_i = 1'b1;
        tick();
        check_val("abt_late_ack_ignored", {30'h0, m1_ack_o, m0_ack_o}, 32'h0);
        check_val("abt_idle_grant", 32'(grant_o), 32'h0);
        check_val("abt_no_err", 32'(err_o), 32'h0);
        mprj_ack_i = 1'b0; slv_en = 1'b1; hk_lat = 1; hk_dat_i = 32'hCAFE_0001;
        m1_set(1'b0, 32'h2600_0008, 32'h0);
        ack_n = 0; ack_at = 0; oth_n = 0; got_dat = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) check_val("abt_next_grant", 32'(grant_o), 32'h2);
            if (m0_ack_o) oth_n++;
            if (m1_ack_o) begin
                ack_n++; ack_at = i; got_dat = m1_dat_o;
                m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
            end
        end
        check_val("abt_next_ack_cycle", 32'(ack_at), 32'd3);
        check_val("abt_next_rdata", got_dat, 32'hCAFE_0001);
        check_val("abt_next_no_m0_ack", 32'(oth_n), 32'd0);

        // User project never acks.
        mprj_lat = -1;
        m0_set(1'b0, 32'h3000_0020, 32'h0);
        mp_n = 0; ack_n = 0; ack_at = 0; err_n = 0; got_dat = 0;
`ifdef MGMT_WB_ARB_TIMEOUT_EN
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (mprj_cyc_o) mp_n++;
            if (err_o) err_n++;
            if (m0_ack_o) begin
                ack_n++; ack_at = i; got_dat = m0_dat_o;
                m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
            end
        end
        check_val("to_cyc_cycles", 32'(mp_n), 32'd15);
        check_val("to_ack_cycle", 32'(ack_at), 32'd17);
        check_val("to_ack_count", 32'(ack_n), 32'd1);
        check_val("to_rdata", got_dat, 32'hDEAD_BEEF);
        check_val("to_err_count", 32'(err_n), 32'd1);
        m0_set(1'b0, 32'h3000_0020, 32'h0);
`else
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (err_o) err_n++;
            if (m0_ack_o) ack_n++;
        end
        check_val("noto_ack_count", 32'(ack_n), 32'd0);
        check_val("noto_err_count", 32'(err_n), 32'd0);
        check_val("noto_cyc_held", 32'(mprj_cyc_o), 32'h1);
`endif

        // Reset in the middle of a busy cycle.
        tick(); tick(); tick();
        check_val("rstb_cyc_up", 32'(mprj_cyc_o), 32'h1);
        check_val("rstb_grant", 32'(grant_o), 32'h1);
        #2;
        core_rst = 1'b1;
        #1;
        check_val("rstb_strobes", {28'h0, hk_cyc_o, hk_stb_o, mprj_cyc_o, mprj_stb_o}, 32'h0);
        check_val("rstb_iena", 32'(mprj_wb_iena), 32'h0);
        check_val("rstb_grant_clear", 32'(grant_o), 32'h0);
        check_val("rstb_sadr_clear", s_adr_o, 32'h0);
        check_val("rstb_acks", {30'h0, m1_ack_o, m0_ack_o}, 32'h0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick(); tick();
        core_rst = 1'b0;
        tick();
        hk_lat = 1; hk_dat_i = 32'h0000_0042;
        m0_set(1'b0, 32'h2600_0000, 32'h0);
        m1_set(1'b0, 32'h2600_0000, 32'h0);
        ack_n = 0; oth_n = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) check_val("rstb_first_tie", 32'(grant_o), 32'h1);
            if (m0_ack_o) begin ack_n++; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
            if (m1_ack_o) begin oth_n++; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
        end
        check_val("rstb_m0_served", 32'(ack_n), 32'd1);
        check_val("rstb_m1_served", 32'(oth_n), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
